// File: rtl/rsa_mod_mult_if.sv
// Request/response bundle for the bit-serial modular multiplier.
// Latency: none; this is a plain signal group.
// Backpressure: none; start is a pulse and is ignored while the unit is busy.
interface rsa_mod_mult_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [2*WIDTH-1:0]   a;
   logic [2*WIDTH-1:0]   b;
   logic [2*WIDTH-1:0]   n;
   logic [2*WIDTH-1:0]   result;
   logic                 busy;
   logic                 finish;

   modport master (
      output start, a, b, n,
      input  result, busy, finish
   );

   modport slave (
      input  start, a, b, n,
      output result, busy, finish
   );
endinterface

// File: rtl/rsa_mod_mult.sv
// Bit-serial interleaved modular multiplier: result = (a * b) mod n.
// Latency: fixed 2*WIDTH+2 edges from accepted start to the finish pulse.
// Backpressure: none; start is accepted only in IDLE, otherwise dropped.
module rsa_mod_mult #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   rsa_mod_mult_if.slave  bus
);

   localparam int W2 = 2 * WIDTH;      // operand width
   localparam int WX = W2 + 2;         // datapath width, headroom for 2*r + a
   localparam int CW = $clog2(W2);     // bit index width

   // WRAP is the settle cycle between the last bit and the finish cycle,
   // which keeps the finish pulse and the busy fall on the same edge.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      WRAP = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state;
   logic [W2-1:0]   a_reg;
   logic [W2-1:0]   b_reg;
   logic [W2-1:0]   n_reg;
   logic [W2-1:0]   r_reg;
   logic [CW-1:0]   cnt;
   logic [W2-1:0]   result_q;
   logic            busy_q;
   logic            finish_q;

   logic [WX-1:0]   n_ext;
   logic [WX-1:0]   a_ext;
   logic [WX-1:0]   t1_raw;
   logic [WX-1:0]   t1;
   logic [WX-1:0]   t2_raw;
   logic [WX-1:0]   t2;

   // One interleaved step: double, reduce, conditionally add a, reduce.
   // Both reductions are always computed and muxed so timing is data-independent.
   always_comb begin
      n_ext  = {2'b00, n_reg};
      a_ext  = {2'b00, a_reg};
      t1_raw = {1'b0, r_reg, 1'b0};
      t1     = (t1_raw >= n_ext) ? (t1_raw - n_ext) : t1_raw;
      t2_raw = t1 + (b_reg[cnt] ? a_ext : '0);
      t2     = (t2_raw >= n_ext) ? (t2_raw - n_ext) : t2_raw;
   end

   // Control FSM with registered outputs and the operand/accumulator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         n_reg    <= '0;
         r_reg    <= '0;
         cnt      <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               finish_q <= 1'b0;
               if (bus.start) begin
                  a_reg  <= bus.a;
                  b_reg  <= bus.b;
                  n_reg  <= bus.n;
                  r_reg  <= '0;
                  cnt    <= CW'(W2 - 1);
                  busy_q <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               r_reg <= W2'(t2);
               cnt   <= cnt - CW'(1);
               if (cnt == '0) begin
                  state <= WRAP;
               end
            end
            WRAP: begin
               // A zero modulus has no meaningful residue; report 0.
               result_q <= (n_reg == '0) ? '0 : r_reg;
               finish_q <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               finish_q <= 1'b0;
               busy_q   <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.finish = finish_q;

endmodule
